countdown_ctrl: RTL
===================

// Module: countdown_ctrl
// PURPOSE
//  Two-digit BCD countdown controller feeding the seven-segment scan/display stage.
//  Takes debounced start/pause and clear key levels plus a switch-loaded BCD preset.
//  Runs a prescaled decrement and presents tens/ones digits and status flags.
//  The display stage consumes bcd_tens_o/bcd_ones_o directly; no decoding happens here.
// PARAMETERS
//  TICK_DIV   100_000_000  clk_i cycles per decrement tick (1 Hz at 100 MHz); >=2
//  START_VAL  8'h10        BCD value loaded at reset and on invalid preset
// PORTS
//  clk_i        in   1  system clock, single clock domain
//  rst          in   1  asynchronous, active-high reset
//  key_start_i  in   1  debounced start/pause key level, asynchronous to clk_i
//  key_clr_i    in   1  debounced clear key level, asynchronous to clk_i
//  load_val_i   in   8  BCD preset {tens,ones} from switches
//  bcd_tens_o   out  4  current tens digit (0..9)
//  bcd_ones_o   out  4  current ones digit (0..9)
//  running_o    out  1  1 while state==RUN
//  done_o       out  1  1 while state==DONE
//  tick_o       out  1  one-cycle pulse on every prescaler wrap
//  blank_o      out  1  display blank request (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE, digits=START_VAL, prescaler=0, all 1-bit outputs 0.
//  - Keys: 2-flop sync + rising-edge detect -> 1-cycle pulse; key change to state change = 3 clk_i.
//  - States IDLE, RUN, PAUSE, DONE. clr pulse has priority over start pulse in every state.
//  - IDLE: start -> RUN (prescaler cleared); if digits==00 -> DONE instead.
//          clr -> reload digits from load_val_i; stay IDLE.
//  - RUN: prescaler counts 0..TICK_DIV-1; wrap asserts tick_o and decrements.
//         start -> PAUSE; clr -> IDLE with reload.
//  - PAUSE: prescaler and digits held; start -> RUN (prescaler resumes, not cleared).
//           clr -> IDLE with reload.
//  - DONE: digits 00; start or clr -> IDLE with reload.
//  - Decrement is BCD: ones>0 -> ones-1; else ones=9, tens-1.
//    A result of 00 moves to DONE in the same cycle the digits update.
//  - Reload: a nibble of load_val_i >9 makes the whole preset invalid; START_VAL loads instead.
//  - Tick and start in the same RUN cycle: apply the decrement, then enter PAUSE.
//  - Tick producing 00 and start in the same cycle: DONE wins.
//  - rst mid-count: immediate return to reset values; no pending pulse survives.
//  - tick_o is 0 outside RUN, except in DONE with COUNTDOWN_BLINK_EN.
// CONFIGURATION
//  COUNTDOWN_BLINK_EN defined:
//   - Prescaler keeps running in DONE; blank_o toggles on each tick.
//   - blank_o clears to 0 on leaving DONE.
//  COUNTDOWN_BLINK_EN undefined: blank_o tied 0; prescaler idle in DONE.
// STRUCTURE
//  - countdown_pkg holds:
//    - typedef enum logic[1:0] {IDLE,RUN,PAUSE,DONE} cd_state_t
//    - typedef logic[3:0] bcd_t
//    - function bcd_valid(bcd_t)
//    - localparam BCD_MAX=4'd9
//  - Sub-module key_edge (sync + rising-edge pulse), instantiated for start and clr.
// TESTING (TICK_DIV=4, START_VAL=8'h10)
//  - Reset: digits 1,0; running_o=0; done_o=0.
//  - start -> running_o after 3 clk. After 4 ticks (16 clk): 0,6.
//    After 10 ticks: 0,0 and done_o=1.
//  - load_val_i=8'h25, clr in IDLE -> 2,5. load_val_i=8'h3A, clr -> 1,0 (invalid preset).
//  - RUN at 0,7; start -> PAUSE; 40 clk idle -> still 0,7. start -> resumes; next tick -> 0,6.
//  - Start and clr edges on the same clk in RUN -> IDLE with reload, running_o=0.
//  - rst pulse mid-RUN at 0,3 -> 1,0, IDLE. With COUNTDOWN_BLINK_EN, in DONE blank_o toggles every 4 clk.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and helpers for the two-digit BCD countdown controller.
package countdown_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cd_state_t;
  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic logic bcd_valid(bcd_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/countdown_ctrl_key_edge.sv
// Key conditioner: two-flop synchroniser followed by a rising-edge detector.
// The one-cycle pulse appears two clocks after the key level changes.
module key_edge (
  input  logic clk_i,
  input  logic rst,
  input  logic key_i,
  output logic pulse_o
);

  // [0],[1] synchronise; [2] holds the previous synchronised level
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], key_i};
    end
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown controller with start/pause and clear keys.
// Define COUNTDOWN_BLINK_EN to keep the prescaler running in DONE and blink the display.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter logic [7:0]  START_VAL = 8'h10
) (
  input  logic       clk_i,
  input  logic       rst,
  input  logic       key_start_i,
  input  logic       key_clr_i,
  input  logic [7:0] load_val_i,
  output logic [3:0] bcd_tens_o,
  output logic [3:0] bcd_ones_o,
  output logic       running_o,
  output logic       done_o,
  output logic       tick_o,
  output logic       blank_o
);

  localparam int unsigned     PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

  logic start_p, clr_p;

  key_edge u_start_edge (.clk_i(clk_i), .rst(rst), .key_i(key_start_i), .pulse_o(start_p));
  key_edge u_clr_edge   (.clk_i(clk_i), .rst(rst), .key_i(key_clr_i),   .pulse_o(clr_p));

  cd_state_t     state_q;
  bcd_t          tens_q, ones_q;
  logic [PW-1:0] presc_q;
  logic          running_q, done_q, tick_q;

  bcd_t          rl_tens_d, rl_ones_d, dec_tens_d, dec_ones_d;
  logic [PW-1:0] presc_inc_d;
  logic          presc_on, wrap, dec_zero, is_zero;

  // An out-of-range nibble anywhere invalidates the whole preset
  always_comb begin
    rl_tens_d = START_VAL[7:4];
    rl_ones_d = START_VAL[3:0];
    if (bcd_valid(load_val_i[7:4]) && bcd_valid(load_val_i[3:0])) begin
      rl_tens_d = load_val_i[7:4];
      rl_ones_d = load_val_i[3:0];
    end
  end

  always_comb begin
    dec_tens_d = tens_q;
    dec_ones_d = ones_q - 4'd1;
    if (ones_q == 4'd0) begin
      dec_tens_d = tens_q - 4'd1;
      dec_ones_d = BCD_MAX;
    end
  end

  assign dec_zero    = (dec_tens_d == 4'd0) && (dec_ones_d == 4'd0);
  assign is_zero     = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign presc_inc_d = presc_q + 1'b1;

`ifdef COUNTDOWN_BLINK_EN
  logic blank_q;
  assign presc_on = (state_q == RUN) || (state_q == DONE);
  assign blank_o  = blank_q;
`else
  assign presc_on = (state_q == RUN);
  assign blank_o  = 1'b0;
`endif

  assign wrap = presc_on && (presc_q == PRESC_LAST);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tens_q    <= START_VAL[7:4];
      ones_q    <= START_VAL[3:0];
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
`ifdef COUNTDOWN_BLINK_EN
      blank_q   <= 1'b0;
`endif
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_p) begin
            tens_q  <= rl_tens_d;
            ones_q  <= rl_ones_d;
            presc_q <= '0;
          end else if (start_p) begin
            presc_q <= '0;
            if (is_zero) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (clr_p) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            tens_q    <= rl_tens_d;
            ones_q    <= rl_ones_d;
            presc_q   <= '0;
          end else begin
            if (wrap) begin
              presc_q <= '0;
              tick_q  <= 1'b1;
              tens_q  <= dec_tens_d;
              ones_q  <= dec_ones_d;
            end else begin
              presc_q <= presc_inc_d;
            end
            // Reaching 00 beats a simultaneous pause request
            if (wrap && dec_zero) begin
              state_q   <= DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else if (start_p) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (clr_p) begin
            state_q <= IDLE;
            tens_q  <= rl_tens_d;
            ones_q  <= rl_ones_d;
            presc_q <= '0;
          end else if (start_p) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        DONE: begin
          if (clr_p || start_p) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            tens_q  <= rl_tens_d;
            ones_q  <= rl_ones_d;
            presc_q <= '0;
`ifdef COUNTDOWN_BLINK_EN
            blank_q <= 1'b0;
          end else if (wrap) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
            blank_q <= ~blank_q;
          end else begin
            presc_q <= presc_inc_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_tens_o = tens_q;
  assign bcd_ones_o = ones_q;
  assign running_o  = running_q;
  assign done_o     = done_q;
  assign tick_o     = tick_q;

endmodule
